// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss controller: field widths,
// controller state encoding and the word-address compose function.
package cache_pkg;

    localparam int TAG_W  = 27;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RF,
        FILL,
        DONE,
        ERR
    } miss_state_e;

    // Lines hold a single word, so the byte offset is always zero.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] index);
        return {tag, index, 2'b00};
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Miss-controller bus bundle: miss capture inputs, main-memory handshake,
// line-array fill port and pipeline status.
interface cache_miss_ctrl_if;
    import cache_pkg::*;

    logic              miss_i;
    logic [TAG_W-1:0]  tag_i;
    logic [IDX_W-1:0]  index_i;
    logic              victim_dirty_i;
    logic [TAG_W-1:0]  victim_tag_i;
    logic [31:0]       victim_data_i;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    logic              fill_we_o;
    logic [IDX_W-1:0]  fill_index_o;
    logic [TAG_W-1:0]  fill_tag_o;
    logic [31:0]       fill_data_o;

    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        input  miss_i, tag_i, index_i, victim_dirty_i, victim_tag_i, victim_data_i,
        input  mem_ack_i, mem_rdata_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output fill_we_o, fill_index_o, fill_tag_o, fill_data_o,
        output busy_o, done_o, err_o
    );

    modport slave (
        output miss_i, tag_i, index_i, victim_dirty_i, victim_tag_i, victim_data_i,
        output mem_ack_i, mem_rdata_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  fill_we_o, fill_index_o, fill_tag_o, fill_data_o,
        input  busy_o, done_o, err_o
    );

endinterface

// File: rtl/cache_miss_ctrl_req_timer.sv
// Per-phase request timer: counts unacknowledged request cycles and the
// number of re-issues, flagging a timeout and the final give-up.
module req_timer #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic timeout,
    output logic give_up
);

    localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    logic [WAIT_W-1:0]  wait_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    // An ack on the threshold cycle suppresses the timeout.
    assign timeout = req && !ack && (wait_cnt == WAIT_LAST);
    assign give_up = timeout && (retry_cnt == RETRY_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt  <= '0;
            retry_cnt <= '0;
        end else if (clear) begin
            wait_cnt  <= '0;
            retry_cnt <= '0;
        end else if (timeout) begin
            wait_cnt  <= '0;
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end else if (req && !ack) begin
            wait_cnt  <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: optional dirty-victim writeback, refill read and
// line-array fill, with per-phase timeout/retry. All outputs are registered.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    cache_miss_ctrl_if.master bus
);

    miss_state_e       state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fill_we_q, fill_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              timer_clear;
    logic              timeout;
    logic              give_up;

    req_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (timer_clear),
        .req     (req_q),
        .ack     (bus.mem_ack_i),
        .timeout (timeout),
        .give_up (give_up)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag_q     <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            fill_we_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tag_q     <= tag_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            fill_we_q <= fill_we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic computes next output values so every output leaves a flop.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        rdata_d     = rdata_q;
        fill_we_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        timer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.miss_i) begin
                    tag_d       = bus.tag_i;
                    idx_d       = bus.index_i;
                    busy_d      = 1'b1;
                    req_d       = 1'b1;
                    timer_clear = 1'b1;
                    if (bus.victim_dirty_i) begin
                        state_d = WB;
                        we_d    = 1'b1;
                        addr_d  = addr_of(bus.victim_tag_i, bus.index_i);
                        wdata_d = bus.victim_data_i;
                    end else begin
                        state_d = RF;
                        we_d    = 1'b0;
                        addr_d  = addr_of(bus.tag_i, bus.index_i);
                    end
                end
            end
            WB, RF: begin
                // A dropped request (after an ack or a timeout) re-asserts next cycle.
                if (req_q && bus.mem_ack_i) begin
                    timer_clear = 1'b1;
                    req_d       = 1'b0;
                    if (state_q == WB) begin
                        state_d = RF;
                        we_d    = 1'b0;
                        addr_d  = addr_of(tag_q, idx_q);
                    end else begin
                        state_d   = FILL;
                        rdata_d   = bus.mem_rdata_i;
                        fill_we_d = 1'b1;
                    end
                end else if (give_up) begin
                    timer_clear = 1'b1;
                    req_d       = 1'b0;
                    state_d     = ERR;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                end else if (timeout) begin
                    req_d = 1'b0;
                end else if (!req_q) begin
                    req_d = 1'b1;
                end
            end
            FILL: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req_o    = req_q;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.fill_we_o    = fill_we_q;
    assign bus.fill_index_o = idx_q;
    assign bus.fill_tag_o   = tag_q;
    assign bus.fill_data_o  = rdata_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

endmodule
